// File: rtl/mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// mem_loader_pkg
// Shared constants and state enumeration for the byte-stream memory loader and
// the 16-bit word memory it fills.
//   WORD_W        : memory word width (bits)
//   BYTE_W        : upstream byte width (bits)
//   DEPTH_DEFAULT : default number of words in the target memory
//   AW_DEFAULT    : default memory address width
//   state_e       : loader FSM states
// -----------------------------------------------------------------------------
package mem_loader_pkg;

    localparam int WORD_W        = 16;
    localparam int BYTE_W        = 8;
    localparam int DEPTH_DEFAULT = 42;
    localparam int AW_DEFAULT    = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

endpackage : mem_loader_pkg

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
// Assembles big-endian byte pairs from a valid/ready byte stream into 16-bit
// words and writes them to consecutive memory addresses 0..n_words-1.
//
// Optional feature (compile-time macro MEM_LOADER_CKSUM_EN):
//   defined   : checksum is the modulo-2^16 sum of the words written by the
//               current load; cleared on an accepted start.
//   undefined : checksum is tied to 0 and no adder exists.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle load request, honoured only in IDLE
//   n_words      : number of words to load, latched on accepted start
//   byte_valid   : upstream byte present
//   byte_data    : upstream byte
//   byte_ready   : loader accepts a byte (HI and LO states)
//   write_enable : one-cycle memory write strobe
//   address      : memory write address (held between writes)
//   data_in      : memory write data (held between writes)
//   busy         : load in progress
//   done         : one-cycle completion pulse
//   error        : n_words exceeded DEPTH on the last accepted start
//   checksum     : running word sum (see macro above)
// -----------------------------------------------------------------------------
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     n_words,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              write_enable,
    output logic [AW-1:0]     address,
    output logic [WORD_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] checksum
);

    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e              state_q, state_d;
    logic [AW-1:0]       n_q;
    logic [AW-1:0]       idx_q;
    logic [AW-1:0]       idx_inc;
    logic [BYTE_W-1:0]   hi_q;
    logic [AW-1:0]       addr_q;
    logic [WORD_W-1:0]   data_q;
    logic                error_q;
    logic                too_many;
    logic                range_ok;
    logic                accept_start;

    assign too_many     = ({1'b0, n_words} > DEPTH_L);
    assign range_ok     = (n_words != '0) && !too_many;
    assign accept_start = (state_q == ST_IDLE) && start;
    assign idx_inc      = idx_q + AW'(1);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = range_ok ? ST_HI : ST_FIN;
                end
            end
            ST_HI: begin
                if (byte_valid) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (byte_valid) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                // idx_q is the index being written; after it the count is idx+1.
                state_d = (idx_inc == n_q) ? ST_FIN : ST_HI;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        byte_ready   = 1'b0;
        write_enable = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_WR: begin
                write_enable = 1'b1;
                busy         = 1'b1;
            end
            ST_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    // address/data_in are loaded on the low-byte transfer so they are valid
    // during WR and keep their value afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            if (accept_start) begin
                n_q     <= n_words;
                idx_q   <= '0;
                error_q <= too_many;
            end
            if ((state_q == ST_HI) && byte_valid) begin
                hi_q <= byte_data;
            end
            if ((state_q == ST_LO) && byte_valid) begin
                data_q <= {hi_q, byte_data};
                addr_q <= idx_q;
            end
            if (state_q == ST_WR) begin
                idx_q <= idx_inc;
            end
        end
    end

    assign address = addr_q;
    assign data_in = data_q;
    assign error   = error_q;

`ifdef MEM_LOADER_CKSUM_EN
    logic [WORD_W-1:0] cksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else if (accept_start) begin
            cksum_q <= '0;
        end else if (state_q == ST_WR) begin
            cksum_q <= cksum_q + data_q;
        end
    end

    assign checksum = cksum_q;
`else
    assign checksum = '0;
`endif

endmodule : mem_loader

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
// Scoreboard bench for mem_loader. Each load pushes its expected writes and
// completion into queues; an independent monitor pops and compares whenever
// the DUT strobes write_enable or done.
// -----------------------------------------------------------------------------
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int DEPTH = 42;
    localparam int AW    = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     n_words = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              write_enable;
    logic [AW-1:0]     address;
    logic [15:0]       data_in;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       checksum;

    mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .n_words      (n_words),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    typedef struct {
        logic        err;
        logic [15:0] cks;
        int          n;
        int          exp_cyc;
    } done_t;

    wr_t         wr_q[$];
    done_t       done_q[$];
    logic [7:0]  byte_q[$];
    logic [7:0]  load_bytes[$];
    int          lat_q[$];
    int          sent_cnt = 0;
    bit          full_rate = 1'b0;
    logic [15:0] mem [DEPTH];
    int          done_cnt = 0;
    int          last_we_cyc = 0;
    int          wr_in_load = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ byte source
    // Bytes are offered with random gaps (or back-to-back at full rate). A
    // transfer of an odd-numbered byte (low byte) predicts a write next cycle.
    initial begin : src
        bit xfer;
        forever begin
            @(negedge clk);
            xfer = byte_valid && byte_ready && rst_n;
            if (xfer && sent_cnt[0]) lat_q.push_back(cyc + 1);
            @(posedge clk);
            #1;
            if (xfer && byte_q.size() > 0) begin
                void'(byte_q.pop_front());
                sent_cnt++;
            end
            if (byte_q.size() > 0) begin
                byte_valid = full_rate ? 1'b1 : ($urandom_range(0, 2) != 0);
                byte_data  = byte_q[0];
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    initial begin : mon
        wr_t   w;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (write_enable) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 32'(address), 32'hFFFF_FFFF);
                    end else begin
                        w = wr_q.pop_front();
                        check("wr_addr", 32'(address), 32'(w.addr));
                        check("wr_data", 32'(data_in), 32'(w.data));
                    end
                    check("addr_in_range", 32'(int'(address) < DEPTH), 32'd1);
                    if (int'(address) < DEPTH) mem[address] = data_in;
                    if (lat_q.size() == 0) begin
                        check("wr_latency", 32'(cyc), 32'hFFFF_FFFF);
                    end else begin
                        check("wr_latency", 32'(cyc), 32'(lat_q.pop_front()));
                    end
                    if (full_rate && wr_in_load > 0)
                        check("wr_gap", 32'(cyc - last_we_cyc), 32'd3);
                    last_we_cyc = cyc;
                    wr_in_load++;
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_error", 32'(error), 32'(d.err));
                        check("done_checksum", 32'(checksum), 32'(d.cks));
                        check("done_busy_low", 32'(busy), 32'd0);
                        check("done_write_count", 32'(wr_in_load), 32'((d.err || d.n == 0) ? 0 : d.n));
                        if (d.err || d.n == 0)
                            check("done_cycle", 32'(cyc), 32'(d.exp_cyc));
                        else
                            check("done_after_wr", 32'(cyc), 32'(last_we_cyc + 1));
                    end
                    wr_in_load = 0;
                    done_cnt++;
                end
            end
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic issue_load(input int n, input bit fr, output int seen);
        logic [15:0] sum;
        logic [15:0] w;
        done_t       d;
        sum = '0;
        if (n > 0 && n <= DEPTH) begin
            if (load_bytes.size() == 0)
                for (int i = 0; i < 2 * n; i++) load_bytes.push_back(8'($urandom));
            for (int i = 0; i < n; i++) begin
                w = {load_bytes[2*i], load_bytes[2*i+1]};
                wr_q.push_back('{addr: AW'(i), data: w});
                sum = sum + w;
                byte_q.push_back(load_bytes[2*i]);
                byte_q.push_back(load_bytes[2*i+1]);
            end
        end
`ifndef MEM_LOADER_CKSUM_EN
        sum = '0;
`endif
        full_rate = fr;
        @(posedge clk);
        #1;
        d = '{err: (n > DEPTH), cks: sum, n: n, exp_cyc: cyc + 1};
        done_q.push_back(d);
        seen = done_cnt;
        start   = 1'b1;
        n_words = AW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        load_bytes.delete();
    endtask

    task automatic wait_done(input int seen);
        for (int k = 0; k < 3000 && done_cnt == seen; k++) @(posedge clk);
        if (done_cnt == seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int n, input bit fr, input bit poke);
        int seen;
        issue_load(n, fr, seen);
        if (poke) begin
            // state is HI or LO here: this start must be ignored
            start   = 1'b1;
            n_words = AW'(7);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(seen);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},         32'(busy),         32'd0);
        check({tag, "_done"},         32'(done),         32'd0);
        check({tag, "_error"},        32'(error),        32'd0);
        check({tag, "_byte_ready"},   32'(byte_ready),   32'd0);
        check({tag, "_write_enable"}, 32'(write_enable), 32'd0);
        check({tag, "_address"},      32'(address),      32'd0);
        check({tag, "_data_in"},      32'(data_in),      32'd0);
        check({tag, "_checksum"},     32'(checksum),     32'd0);
    endtask

    // --------------------------------------------------------------- watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin : stim
        logic [15:0] w0;
        int          seen;
        int          base;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // two-word reference case: 1234, ABCD, checksum BE01
        load_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        do_load(2, 1'b0, 1'b0);
        check("ref_mem0", 32'(mem[0]), 32'h1234);
        check("ref_mem1", 32'(mem[1]), 32'hABCD);

        // over-range and empty loads
        do_load(43, 1'b0, 1'b0);
        do_load(0, 1'b0, 1'b0);

        // start pulse during an active 3-word load
        do_load(3, 1'b0, 1'b1);

        // full-depth load with random byte_valid gaps
        do_load(42, 1'b0, 1'b0);

        // full-rate load: one word every 3 cycles
        do_load(5, 1'b1, 1'b0);

        // random loads, including occasional out-of-range counts
        for (int t = 0; t < 10; t++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 63) : $urandom_range(1, 8);
            do_load(n, 1'b0, 1'b0);
        end

        // reset after the high byte of word 1
        load_bytes = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom)};
        w0 = {load_bytes[0], load_bytes[1]};
        base = sent_cnt;
        issue_load(3, 1'b0, seen);
        for (int k = 0; k < 500 && sent_cnt < base + 3; k++) begin
            @(posedge clk);
            #2;
        end
        check("reset_wait_hi_byte", 32'(sent_cnt >= base + 3), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        check("midreset_mem0_kept", 32'(mem[0]), 32'(w0));
        wr_q.delete();
        done_q.delete();
        byte_q.delete();
        lat_q.delete();
        sent_cnt   = 0;
        byte_valid = 1'b0;
        wr_in_load = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        load_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        do_load(2, 1'b0, 1'b0);
        check("post_reset_mem0", 32'(mem[0]), 32'h1234);
        check("post_reset_mem1", 32'(mem[1]), 32'hABCD);

        repeat (3) @(posedge clk);
        check("leftover_writes", 32'(wr_q.size()), 32'd0);
        check("leftover_dones",  32'(done_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_loader
